// File: rtl/lsm_expander.sv
// Load/store-multiple expander between fetch and decode.
// Ports: clk/reset/flush, in_valid/in_ready/in_insn, out_valid/out_ready/
//   out_insn/out_last/out_illegal/out_dovf, busy.
module lsm_expander #(
  parameter bit ENABLE_LMW  = 1'b1,
  parameter bit ENABLE_STMW = 1'b1,
  parameter int DISP_STEP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_last,
  output logic        out_illegal,
  output logic        out_dovf,
  output logic        busy
);

  localparam logic [5:0] OP_LMW  = 6'd46;
  localparam logic [5:0] OP_STMW = 6'd47;
  localparam logic [5:0] OP_LWZ  = 6'd32;
  localparam logic [5:0] OP_STW  = 6'd36;
  localparam logic [16:0] STEP   = 17'(DISP_STEP);

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  state_t      r_state;
  logic        r_out_valid;
  logic [31:0] r_out_insn;
  logic        r_out_last;
  logic        r_out_illegal;
  logic        r_out_dovf;
  logic        r_op_st;
  logic [4:0]  r_ra;
  logic [4:0]  r_cnt;
  logic [16:0] r_disp;

  state_t      w_state_n;
  logic        w_out_valid_n;
  logic [31:0] w_out_insn_n;
  logic        w_out_last_n;
  logic        w_out_illegal_n;
  logic        w_out_dovf_n;
  logic        w_op_st_n;
  logic [4:0]  w_ra_n;
  logic [4:0]  w_cnt_n;
  logic [16:0] w_disp_n;

  logic [5:0]  w_opc;
  logic [4:0]  w_rt;
  logic [4:0]  w_ra;
  logic [15:0] w_d;
  logic [16:0] w_d_ext;
  logic        w_is_lmw;
  logic        w_is_stmw;
  logic        w_lmw_bad;
  logic        w_expand;
  logic        w_accept;
  logic        w_disp_ovf;

  assign w_opc   = in_insn[31:26];
  assign w_rt    = in_insn[25:21];
  assign w_ra    = in_insn[20:16];
  assign w_d     = in_insn[15:0];
  assign w_d_ext = {w_d[15], w_d};

  assign w_is_lmw  = ENABLE_LMW && (w_opc == OP_LMW);
  assign w_is_stmw = ENABLE_STMW && (w_opc == OP_STMW);
  // LMW whose range would overwrite its own base register.
  assign w_lmw_bad = w_is_lmw && (w_ra != 5'd0) && (w_rt <= w_ra);
  assign w_expand  = (w_is_lmw && !w_lmw_bad) || w_is_stmw;

  assign in_ready = (r_state == IDLE) && !flush
                    && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // 17-bit displacement is outside 16-bit signed range.
  assign w_disp_ovf = r_disp[16] ^ r_disp[15];

  always_comb begin
    w_state_n       = r_state;
    w_out_valid_n   = r_out_valid;
    w_out_insn_n    = r_out_insn;
    w_out_last_n    = r_out_last;
    w_out_illegal_n = r_out_illegal;
    w_out_dovf_n    = r_out_dovf;
    w_op_st_n       = r_op_st;
    w_ra_n          = r_ra;
    w_cnt_n         = r_cnt;
    w_disp_n        = r_disp;
    if (flush) begin
      w_state_n     = IDLE;
      w_out_valid_n = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_out_valid_n = 1'b1;
            w_out_dovf_n  = 1'b0;
            if (w_expand) begin
              w_out_insn_n    = {w_is_stmw ? OP_STW : OP_LWZ,
                                 w_rt, w_ra, w_d};
              w_out_illegal_n = 1'b0;
              if (w_rt == 5'd31) begin
                w_out_last_n = 1'b1;
              end else begin
                w_out_last_n = 1'b0;
                w_state_n    = EXPAND;
                w_op_st_n    = w_is_stmw;
                w_ra_n       = w_ra;
                w_cnt_n      = w_rt + 5'd1;
                w_disp_n     = w_d_ext + STEP;
              end
            end else begin
              w_out_insn_n    = in_insn;
              w_out_last_n    = 1'b1;
              w_out_illegal_n = w_lmw_bad;
            end
          end else if (out_ready) begin
            w_out_valid_n = 1'b0;
          end
        end
        EXPAND: begin
          if (r_out_valid && out_ready) begin
            w_out_valid_n   = 1'b1;
            w_out_insn_n    = {r_op_st ? OP_STW : OP_LWZ,
                               r_cnt, r_ra, r_disp[15:0]};
            w_out_last_n    = (r_cnt == 5'd31);
            w_out_illegal_n = 1'b0;
            w_out_dovf_n    = w_disp_ovf;
            w_cnt_n         = r_cnt + 5'd1;
            w_disp_n        = r_disp + STEP;
            if (r_cnt == 5'd31) begin
              w_state_n = IDLE;
            end
          end
        end
        default: begin
          w_state_n     = IDLE;
          w_out_valid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_out_valid   <= 1'b0;
      r_out_insn    <= '0;
      r_out_last    <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_dovf    <= 1'b0;
      r_op_st       <= 1'b0;
      r_ra          <= '0;
      r_cnt         <= '0;
      r_disp        <= '0;
    end else begin
      r_state       <= w_state_n;
      r_out_valid   <= w_out_valid_n;
      r_out_insn    <= w_out_insn_n;
      r_out_last    <= w_out_last_n;
      r_out_illegal <= w_out_illegal_n;
      r_out_dovf    <= w_out_dovf_n;
      r_op_st       <= w_op_st_n;
      r_ra          <= w_ra_n;
      r_cnt         <= w_cnt_n;
      r_disp        <= w_disp_n;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_insn    = r_out_insn;
  assign out_last    = r_out_last;
  assign out_illegal = r_out_illegal;
  assign out_dovf    = r_out_dovf;
  assign busy        = (r_state == EXPAND);

endmodule

// File: tb/tb_lsm_expander.sv
// Bench for lsm_expander: directed steps, scoreboard of expected beats.
// A second instance covers ENABLE_LMW=0.
module tb_lsm_expander;

  typedef struct packed {
    logic [31:0] insn;
    logic        last;
    logic        ill;
    logic        dovf;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_insn = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_insn;
  logic        out_last;
  logic        out_illegal;
  logic        out_dovf;
  logic        busy;

  logic        n_flush = 1'b0;
  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [31:0] n_in_insn = '0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b1;
  logic [31:0] n_out_insn;
  logic        n_out_last;
  logic        n_out_illegal;
  logic        n_out_dovf;
  logic        n_busy;

  int checks = 0;
  int errors = 0;

  beat_t sb[$];
  beat_t sb2[$];

  always #5 clk = ~clk;

  lsm_expander u_dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_insn    (in_insn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_insn   (out_insn),
    .out_last   (out_last),
    .out_illegal(out_illegal),
    .out_dovf   (out_dovf),
    .busy       (busy)
  );

  lsm_expander #(.ENABLE_LMW(1'b0)) u_nl (
    .clk        (clk),
    .reset      (reset),
    .flush      (n_flush),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .in_insn    (n_in_insn),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_insn   (n_out_insn),
    .out_last   (n_out_last),
    .out_illegal(n_out_illegal),
    .out_dovf   (n_out_dovf),
    .busy       (n_busy)
  );

  always @(negedge clk) begin
    beat_t e;
    beat_t o;
    if (!reset && out_valid && out_ready) begin
      o = '{out_insn, out_last, out_illegal, out_dovf};
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat obs=%h exp=none", o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL beat obs=%h exp=%h", o, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    beat_t o;
    if (!reset && n_out_valid && n_out_ready) begin
      o = '{n_out_insn, n_out_last, n_out_illegal, n_out_dovf};
      checks++;
      assert (sb2.size() != 0) else begin
        errors++;
        $error("FAIL nl_unexpected_beat obs=%h exp=none", o);
      end
      if (sb2.size() != 0) begin
        e = sb2.pop_front();
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL nl_beat obs=%h exp=%h", o, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic l,
                      input logic il, input logic d);
    sb.push_back('{i, l, il, d});
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_insn  = w;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [31:0] w);
    int n;
    n = 0;
    n_in_valid = 1'b1;
    n_in_insn  = w;
    while (!n_in_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("nl_accept", 32'(n_in_ready), 32'd1);
    cyc();
    n_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || sb2.size() != 0 || out_valid) && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, 32'(sb.size() + sb2.size()), 32'd0);
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_insn", out_insn, 32'd0);
    chk("rst_flags", {29'd0, out_last, out_illegal, out_dovf}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_ready", 32'(in_ready), 32'd1);

    // LMW r29,8(r1)
    push(32'h83A10008, 1'b0, 1'b0, 1'b0);
    push(32'h83C1000C, 1'b0, 1'b0, 1'b0);
    push(32'h83E10010, 1'b1, 1'b0, 1'b0);
    send(32'hBBA10008);
    chk("lmw_rdy0", 32'(in_ready), 32'd0);
    chk("lmw_busy", 32'(busy), 32'd1);
    cyc();
    chk("lmw_rdy1", 32'(in_ready), 32'd0);
    cyc();
    chk("lmw_rdy2", 32'(in_ready), 32'd1);
    chk("lmw_last", 32'(out_last), 32'd1);
    drain("lmw_drain");

    // STMW r30,-4(r1) with a 3-cycle stall on beat 0
    out_ready = 1'b0;
    push(32'h93C1FFFC, 1'b0, 1'b0, 1'b0);
    push(32'h93E10000, 1'b1, 1'b0, 1'b0);
    send(32'hBFC1FFFC);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_insn", out_insn, 32'h93C1FFFC);
      cyc();
    end
    out_ready = 1'b1;
    drain("stmw_drain");

    // LMW r30,0x7FFC(r2): second beat overflows
    push(32'h83C27FFC, 1'b0, 1'b0, 1'b0);
    push(32'h83E28000, 1'b1, 1'b0, 1'b1);
    send(32'hBBC27FFC);
    drain("dovf_drain");

    // Invalid LMW form, then ADDI pass-through
    push(32'hBB9E0000, 1'b1, 1'b1, 1'b0);
    push(32'h38600001, 1'b1, 1'b0, 1'b0);
    send(32'hBB9E0000);
    send(32'h38600001);
    drain("pass_drain");

    // Flush while beat 1 is presented
    push(32'h83A10008, 1'b0, 1'b0, 1'b0);
    send(32'hBBA10008);
    cyc();
    chk("fl_beat1", out_insn, 32'h83C1000C);
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_rdy", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    cyc();
    chk("fl_rdy_after", 32'(in_ready), 32'd1);
    chk("fl_valid2", 32'(out_valid), 32'd0);
    drain("fl_drain");

    // Reset mid-expansion
    push(32'h83A10008, 1'b0, 1'b0, 1'b0);
    send(32'hBBA10008);
    cyc();
    out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_insn", out_insn, 32'd0);
    chk("rs_rdy", 32'(in_ready), 32'd1);
    drain("rs_drain");

    // Back-to-back STMW r31,0(r1) then ADDI
    push(32'h93E10000, 1'b1, 1'b0, 1'b0);
    push(32'h38600001, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_insn  = 32'hBFE10000;
    chk("b2b_rdy0", 32'(in_ready), 32'd1);
    cyc();
    chk("b2b_beat0", out_insn, 32'h93E10000);
    in_insn = 32'h38600001;
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("b2b_beat1", out_insn, 32'h38600001);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    drain("b2b_drain");

    // ENABLE_LMW=0 instance passes LMW through
    sb2.push_back('{32'hBBA10008, 1'b1, 1'b0, 1'b0});
    send2(32'hBBA10008);
    chk("nl_busy", 32'(n_busy), 32'd0);
    chk("nl_rdy", 32'(n_in_ready), 32'd1);
    drain("nl_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
